// File: rtl/frame_pixel_streamer.sv
// Raster-order scanner for a synchronous-read frame buffer. Issues one read
// per cycle (unless paused), optionally idles LINE_GAP cycles between lines,
// and presents the returned pixel with its registered x/y coordinates.
module frame_pixel_streamer #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int ADDR_W     = 17,
  parameter int LINE_GAP   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pixel_out,
  output logic [X_W-1:0]    x_pos,
  output logic [Y_W-1:0]    y_pos,
  output logic              valid_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMG_HEIGHT - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, READ, GAP, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                busy_q, busy_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [X_W-1:0]      rd_x_q, rd_x_d;
  logic [Y_W-1:0]      rd_y_q, rd_y_d;
  logic                rd_last_q, rd_last_d;
  logic [X_W-1:0]      x_pos_q;
  logic [Y_W-1:0]      y_pos_q;
  logic                valid_q;
  logic                frame_done_q;

  logic                issue;
  logic [X_W-1:0]      cur_x;
  logic [Y_W-1:0]      cur_y;
  logic [ADDR_W-1:0]   cur_addr;

  // Next-state and read-issue logic. The first read is issued straight from
  // IDLE (with counters forced to zero) so mem_rd_en rises the cycle after start.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    gap_d      = gap_q;
    busy_d     = busy_q;
    rd_en_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    rd_x_d     = rd_x_q;
    rd_y_d     = rd_y_q;
    rd_last_d  = 1'b0;
    issue      = 1'b0;
    cur_x      = x_q;
    cur_y      = y_q;
    cur_addr   = addr_q;

    if (frame_done_q) busy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          busy_d   = 1'b1;
          state_d  = READ;
          cur_x    = '0;
          cur_y    = '0;
          cur_addr = '0;
          x_d      = '0;
          y_d      = '0;
          addr_d   = '0;
          issue    = !pause;
        end
      end
      READ:  issue = !pause;
      GAP: begin
        if (gap_q == '0) state_d = READ;
        else             gap_d   = gap_q - 1'b1;
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      rd_en_d    = 1'b1;
      mem_addr_d = cur_addr;
      rd_x_d     = cur_x;
      rd_y_d     = cur_y;
      addr_d     = cur_addr + 1'b1;
      if (cur_x == X_LAST) begin
        x_d = '0;
        if (cur_y == Y_LAST) begin
          rd_last_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          y_d = cur_y + 1'b1;
          if (LINE_GAP > 0) begin
            state_d = GAP;
            gap_d   = GAP_INIT;
          end else begin
            state_d = READ;
          end
        end
      end else begin
        x_d     = cur_x + 1'b1;
        state_d = READ;
      end
    end
  end

  // FSM, counters and read-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      gap_q      <= '0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      mem_addr_q <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
      rd_en_q    <= rd_en_d;
      mem_addr_q <= mem_addr_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Output stage: coordinates follow their read by one cycle, aligned with the RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos_q      <= '0;
      y_pos_q      <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_q      <= rd_en_q;
      frame_done_q <= rd_en_q & rd_last_q;
      if (rd_en_q) begin
        x_pos_q <= rd_x_q;
        y_pos_q <= rd_y_q;
      end
    end
  end

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign pixel_out  = mem_rdata;
  assign x_pos      = x_pos_q;
  assign y_pos      = y_pos_q;
  assign valid_out  = valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer on an 8x4 image: instance 0 runs with no line
// gap, instance 1 with LINE_GAP=3. Each has a RAM model returning data = address.
module tb_frame_pixel_streamer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  typedef struct {
    logic [7:0] pix;
    logic [2:0] x;
    logic [1:0] y;
    logic       fd;
  } beat_t;

  typedef struct {
    int sel;
    int pause_at;
    int pause_len;
    int restart_at;
    int exp_len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause = 1'b0;
  logic       start_a [2];
  logic       rden_a  [2];
  logic [4:0] addr_a  [2];
  logic [7:0] rdata_a [2];
  logic [7:0] pix_a   [2];
  logic [2:0] x_a     [2];
  logic [1:0] y_a     [2];
  logic       val_a   [2];
  logic       busy_a  [2];
  logic       fd_a    [2];

  beat_t sbq [2][$];
  int    beats     [2];
  int    bc        [2][N];
  bit    done_flag [2];
  int    done_cyc  [2];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_pixel_streamer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .X_W(3), .Y_W(2), .ADDR_W(5), .LINE_GAP(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .pause(pause),
    .mem_rd_en(rden_a[0]), .mem_addr(addr_a[0]), .mem_rdata(rdata_a[0]),
    .pixel_out(pix_a[0]), .x_pos(x_a[0]), .y_pos(y_a[0]),
    .valid_out(val_a[0]), .busy(busy_a[0]), .frame_done(fd_a[0])
  );

  frame_pixel_streamer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .X_W(3), .Y_W(2), .ADDR_W(5), .LINE_GAP(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .pause(pause),
    .mem_rd_en(rden_a[1]), .mem_addr(addr_a[1]), .mem_rdata(rdata_a[1]),
    .pixel_out(pix_a[1]), .x_pos(x_a[1]), .y_pos(y_a[1]),
    .valid_out(val_a[1]), .busy(busy_a[1]), .frame_done(fd_a[1])
  );

  // Synchronous-read RAM models, contents = address.
  always @(posedge clk) begin
    if (rden_a[0]) rdata_a[0] <= {3'b000, addr_a[0]};
    if (rden_a[1]) rdata_a[1] <= {3'b000, addr_a[1]};
  end

  task automatic chk(input string nm, input int s, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", nm, s, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input int s, input string tag);
    chk({tag, "_rd_en"}, s, 32'(rden_a[s]), 0);
    chk({tag, "_addr"},  s, 32'(addr_a[s]), 0);
    chk({tag, "_x"},     s, 32'(x_a[s]),    0);
    chk({tag, "_y"},     s, 32'(y_a[s]),    0);
    chk({tag, "_valid"}, s, 32'(val_a[s]),  0);
    chk({tag, "_busy"},  s, 32'(busy_a[s]), 0);
    chk({tag, "_fdone"}, s, 32'(fd_a[s]),   0);
  endtask

  task automatic push_frame(input int s);
    beat_t b;
    for (int i = 0; i < N; i++) begin
      b.pix = 8'(i);
      b.x   = 3'(i % W);
      b.y   = 2'(i / W);
      b.fd  = (i == N - 1);
      sbq[s].push_back(b);
    end
    beats[s]     = 0;
    done_flag[s] = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every beat.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        if (val_a[s]) begin
          if (sbq[s].size() == 0) begin
            chk("unexpected_beat", s, 1, 0);
          end else begin
            beat_t e;
            e = sbq[s].pop_front();
            chk("pixel", s, 32'(pix_a[s]), 32'(e.pix));
            chk("x_pos", s, 32'(x_a[s]),   32'(e.x));
            chk("y_pos", s, 32'(y_a[s]),   32'(e.y));
            chk("frame_done", s, 32'(fd_a[s]), 32'(e.fd));
          end
          if (beats[s] < N) bc[s][beats[s]] = cyc;
          beats[s]++;
          if (fd_a[s]) begin
            done_flag[s] = 1'b1;
            done_cyc[s]  = cyc;
          end
        end else begin
          chk("frame_done_idle", s, 32'(fd_a[s]), 0);
        end
      end
    end
  end

  // Called just after a rising edge; drives start in the current cycle.
  task automatic run_frame(input int s, input int pause_at, input int pause_len,
                           input int restart_at, input int exp_len);
    int start_cyc;
    int pcnt;
    bit pdone;
    bit rdone;
    push_frame(s);
    start_a[s] = 1'b1;
    start_cyc  = cyc;
    @(posedge clk); #1;
    start_a[s] = 1'b0;
    chk("first_rd_en", s, 32'(rden_a[s]), 1);
    chk("first_addr",  s, 32'(addr_a[s]), 0);
    chk("busy_after_start", s, 32'(busy_a[s]), 1);
    pcnt  = 0;
    pdone = 1'b0;
    rdone = 1'b0;
    for (int t = 0; t < 300 && !done_flag[s]; t++) begin
      @(posedge clk); #1;
      pause      = 1'b0;
      start_a[s] = 1'b0;
      if (!pdone && pause_at >= 0 && beats[s] > pause_at) begin
        pdone = 1'b1;
        pcnt  = pause_len;
      end
      if (pcnt > 0) begin
        pause = 1'b1;
        pcnt--;
      end
      if (!rdone && restart_at >= 0 && beats[s] > restart_at) begin
        rdone      = 1'b1;
        start_a[s] = 1'b1;
      end
    end
    pause = 1'b0;
    if (!done_flag[s]) begin
      chk("frame_done_timeout", s, 0, 1);
      sbq[s].delete();
    end else begin
      chk("frame_len", s, 32'(done_cyc[s] - start_cyc + 1), 32'(exp_len));
    end
    chk("beat_count", s, 32'(beats[s]), 32'(N));
    chk("queue_empty", s, 32'(sbq[s].size()), 0);
    @(posedge clk); #1;
    chk("busy_after_done", s, 32'(busy_a[s]), 0);
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{sel: 0, pause_at: -1, pause_len: 0, restart_at: -1, exp_len: 2 + N};
    vecs[1] = '{sel: 1, pause_at: -1, pause_len: 0, restart_at: -1, exp_len: 2 + N + 9};
    vecs[2] = '{sel: 0, pause_at: 10, pause_len: 5, restart_at: -1, exp_len: 2 + N + 5};
    vecs[3] = '{sel: 0, pause_at: -1, pause_len: 0, restart_at: 5,  exp_len: 2 + N};

    start_a[0] = 1'b0;
    start_a[1] = 1'b0;
    beats[0] = 0;
    beats[1] = 0;
    done_flag[0] = 1'b0;
    done_flag[1] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].sel, vecs[v].pause_at, vecs[v].pause_len,
                vecs[v].restart_at, vecs[v].exp_len);
      if (vecs[v].sel == 1) begin
        for (int i = 1; i < N; i++)
          chk("gap_spacing", 1, 32'(bc[1][i] - bc[1][i-1]), (i % W == 0) ? 32'd4 : 32'd1);
      end
    end

    // Start in the cycle right after frame_done: accepted, fresh frame from address 0.
    run_frame(0, -1, 0, -1, 2 + N);

    // Asynchronous reset in the middle of a frame.
    push_frame(0);
    start_a[0] = 1'b1;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    for (int t = 0; t < 200 && beats[0] < 21; t++) begin
      @(negedge clk); #1;
    end
    chk("reach_beat20", 0, 32'(beats[0] >= 21), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(0, "midreset");
    sbq[0].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, -1, 0, -1, 2 + N);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
